sr_serial_rx: RTL
=================

// Module: sr_serial_rx
// PURPOSE
//   Serial-to-parallel frame receiver. It is the far end of a link driven by a W_74HC194-style
//   shift register that is parallel-loaded and then shifted out one bit at a time.
//   It samples one serial line, detects start/data/parity/stop framing, and presents each
//   received word as a parallel bus with a one-cycle valid strobe and error flags.
//   It sits between the serial pin (already in the clk domain) and downstream parallel logic.
// PARAMETERS
//   DATA_W     4   data bits per frame (>=2)
//   MSB_FIRST  1   1: first data bit received lands in dout[DATA_W-1]; 0: first lands in dout[0]
// PORTS
//   clk         in   1        system clock, rising edge
//   mr          in   1        asynchronous reset, active-high
//   bit_en      in   1        bit-time enable; sdi is sampled only on clk edges where bit_en=1
//   sdi         in   1        serial data line, idles 1
//   dout        out  DATA_W   last good word received
//   dout_valid  out  1        1-cycle pulse: dout updated
//   parity_err  out  1        qualifies dout_valid: even-parity check failed
//   frame_err   out  1        1-cycle pulse: stop bit sampled 0
//   busy        out  1        1 whenever state != IDLE
// BEHAVIOUR
//   - Frame format: start(0), DATA_W data bits, even-parity bit, stop(1).
//     The parity bit makes the count of 1s across data+parity even.
//   - Reset (mr=1, async): state=IDLE, shift reg=0, bit counter=0.
//     dout=0, dout_valid=0, parity_err=0, frame_err=0, busy=0.
//   - bit_en=0: state, counter and shift reg hold; strobes stay 0.
//   - FSM, all transitions on clk edges with bit_en=1:
//     IDLE:   sdi=0 -> DATA, cnt=0; sdi=1 -> stay.
//     DATA:   shift sdi in, cnt++.
//             MSB_FIRST=1: sr <= {sr[W-2:0],sdi}. MSB_FIRST=0: sr <= {sdi,sr[W-1:1]}.
//             cnt==DATA_W-1 -> PARITY.
//     PARITY: pbit <= sdi -> STOP.
//     STOP:   sdi=1 -> dout<=sr, dout_valid=1, parity_err=(^sr)^pbit, go IDLE.
//             sdi=0 -> frame_err=1, dout/parity_err unchanged, go BREAK.
//     BREAK:  sdi=1 -> IDLE; sdi=0 -> stay (no re-arm on a stuck-low line).
//   - Latency: dout, dout_valid and parity_err are registered. They are visible the cycle after
//     the edge that samples the stop bit.
//   - Strobes: dout_valid and frame_err last exactly one clk, then return to 0.
//     parity_err holds until the next dout_valid.
//   - Back-to-back frames: a start bit may be sampled on the first bit_en edge after the stop bit.
//   - Reset mid-frame discards the partial word; no strobes are produced for it.
//   - Counter width is $clog2(DATA_W); it never exceeds DATA_W-1.
// STRUCTURE
//   - Shared package sr_pkg: state encoding localparams ST_IDLE/ST_DATA/ST_PARITY/ST_STOP/ST_BREAK
//     and the shift-mode encoding (HOLD=2'b00, SHR=2'b01, SHL=2'b10, LOAD=2'b11).
//     The shift-mode encoding is shared with W_74HC194.
//   - One sub-module: sr_shift_core.
//     - Parameterised universal shift register: mr, s[1:0], serial in, parallel in/out.
//     - The FSM drives s=SHR or SHL during DATA (chosen by MSB_FIRST) and HOLD otherwise.
//   - FSM, counter, parity and output registers live in sr_serial_rx.
// TESTING (DATA_W=4, bit_en=1 every cycle unless stated)
//   1. MSB_FIRST=1, sdi 0,0,1,1,0,0,1 -> after stop: dout=4'b0110, dout_valid 1 clk, parity_err=0.
//   2. sdi 0,1,0,1,1,0,1 (odd ones, parity 0) -> dout=4'b1011, dout_valid=1, parity_err=1.
//   3. sdi 0,1,1,1,1,0,0 (stop=0) -> frame_err 1 clk, no dout_valid, dout unchanged.
//      Hold sdi=0 for 5 cycles: busy=1, no strobes. Then sdi=1 and frame 0,1,0,0,1,0,1
//      -> dout=4'b1001.
//   4. bit_en high every 3rd cycle, frame 1 stretched -> same dout=4'b0110.
//      dout_valid asserts only after the 7th enabled edge.
//   5. mr=1 pulse after 2 data bits -> all outputs 0, busy=0 asynchronously.
//      Next full frame 0,1,0,0,1,0,1 -> dout=4'b1001.
//   6. MSB_FIRST=0, sdi 0,0,1,1,1,1,1 -> dout=4'b1110, parity_err=0.
//      Back-to-back second frame with no idle gap also received.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared encodings for the serial frame receiver and its shift-register core.
// The shift-mode encoding matches the far-end W_74HC194 driver.
package sr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
    } sr_state_t;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } sr_mode_t;

endpackage

// File: rtl/sr_serial_rx_if.sv
// Serial-in / parallel-out bundle between the line sampler and downstream logic.
interface sr_serial_rx_if #(
    parameter int DATA_W = 4
);
    logic              bit_en;
    logic              sdi;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output bit_en, sdi,
        input  dout, dout_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  bit_en, sdi,
        output dout, dout_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/sr_shift_core.sv
// Universal shift register with 74HC194-style modes: SHR fills from q[0] upward,
// SHL fills from q[W-1] downward, LOAD takes the parallel input.
module sr_shift_core
    import sr_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         mr,
    input  sr_mode_t     s,
    input  logic         dsr,
    input  logic         dsl,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            q <= '0;
        end else begin
            case (s)
                HOLD:    q <= q;
                SHR:     q <= {q[W-2:0], dsr};
                SHL:     q <= {dsl, q[W-1:1]};
                LOAD:    q <= d;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/sr_serial_rx.sv
// Frame receiver: start(0), DATA_W data bits, even parity, stop(1).
// Sampling happens only on clk edges qualified by bit_en.
module sr_serial_rx
    import sr_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           mr,
    sr_serial_rx_if.slave  rx
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    sr_state_t         state_q, state_d;
    sr_mode_t          mode;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pbit_q, pbit_d;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;

    // The first received bit ends up in the MSB when shifting towards higher indices.
    sr_shift_core #(.W(DATA_W)) u_core (
        .clk (clk),
        .mr  (mr),
        .s   (mode),
        .dsr (rx.sdi),
        .dsl (rx.sdi),
        .d   ('0),
        .q   (sr_q)
    );

    always_ff @(posedge clk or posedge mr) begin
        if (mr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pbit_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pbit_q  <= pbit_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pbit_d  = pbit_q;
        mode    = HOLD;
        dout_d  = dout_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = 1'b0;
        if (rx.bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx.sdi) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
                ST_DATA: begin
                    mode = MSB_FIRST ? SHR : SHL;
                    // Wrap on the last bit so the counter never leaves 0..DATA_W-1.
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_PARITY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    pbit_d  = rx.sdi;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (rx.sdi) begin
                        dout_d  = sr_q;
                        valid_d = 1'b1;
                        perr_d  = (^sr_q) ^ pbit_q;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (rx.sdi) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rx.dout       = dout_q;
    assign rx.dout_valid = valid_q;
    assign rx.parity_err = perr_q;
    assign rx.frame_err  = ferr_q;
    assign rx.busy       = (state_q != ST_IDLE);

endmodule
